// File: rtl/bin_to_seg_encoder.sv
// Binary (0..9999) to 4-digit 7-segment word using sequential double-dabble.
// Byte k of o_seg_data drives digit k (byte 0 = ones); bit7 of each byte is the dp.
module bin_to_seg_encoder #(
    parameter bit P_ACTIVE_LOW = 1'b1,
    parameter bit P_BLANK_LZ   = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [13:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic        i_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_seg_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ENCODE = 2'd2
    } state_t;

    localparam logic [31:0] SEG_OFF = {32{P_ACTIVE_LOW}};

    state_t      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  dp_q, dp_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] seg_q, seg_d;

    logic [15:0] bcd_adj;
    logic [3:0]  digit_zero;
    logic [3:0]  digit_blank;
    logic [31:0] seg_word;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] nib;
            logic [6:0] seg7;
            logic [7:0] byte_ah;

            assign nib = bcd_q[gi*4 +: 4];
            assign bcd_adj[gi*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
            assign digit_zero[gi] = (nib == 4'd0);

            always_comb begin
                seg7 = glyph(nib);
                if (ovf_q) begin
                    seg7 = 7'h40;
                end else if (digit_blank[gi]) begin
                    seg7 = 7'h00;
                end
            end

            assign byte_ah = {dp_q[gi], seg7};
            assign seg_word[gi*8 +: 8] = P_ACTIVE_LOW ? ~byte_ah : byte_ah;
        end
    endgenerate

    // A digit blanks only when it and every more-significant digit are zero.
    assign digit_blank[0] = 1'b0;
    assign digit_blank[1] = P_BLANK_LZ & digit_zero[3] & digit_zero[2] & digit_zero[1];
    assign digit_blank[2] = P_BLANK_LZ & digit_zero[3] & digit_zero[2];
    assign digit_blank[3] = P_BLANK_LZ & digit_zero[3];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dp_q    <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            seg_q   <= SEG_OFF;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            seg_q   <= seg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_valid) state_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == 4'd13) state_d = ST_ENCODE;
            ST_ENCODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        dp_d   = dp_q;
        ovf_d  = ovf_q;
        busy_d = busy_q;
        done_d = 1'b0;
        seg_d  = seg_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    bin_d  = i_value;
                    dp_d   = i_dp;
                    ovf_d  = (i_value > 14'd9999);
                    bcd_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + 4'd1;
            end
            ST_ENCODE: begin
                seg_d  = seg_word;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_seg_data = seg_q;

endmodule

// File: tb/tb_bin_to_seg_encoder.sv
// Directed bench for bin_to_seg_encoder: three parameter variants share one stimulus.
module tb_bin_to_seg_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [13:0] value;
    logic [3:0]  dp;

    logic        busy, done;
    logic [31:0] seg;
    logic        busy_nb, done_nb;
    logic [31:0] seg_nb;
    logic        busy_ah, done_ah;
    logic [31:0] seg_ah;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bin_to_seg_encoder #(.P_ACTIVE_LOW(1'b1), .P_BLANK_LZ(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_value(value), .i_dp(dp), .i_valid(valid),
        .o_busy(busy), .o_done(done), .o_seg_data(seg)
    );

    bin_to_seg_encoder #(.P_ACTIVE_LOW(1'b1), .P_BLANK_LZ(1'b0)) dut_nb (
        .i_clk(clk), .i_rst(rst), .i_value(value), .i_dp(dp), .i_valid(valid),
        .o_busy(busy_nb), .o_done(done_nb), .o_seg_data(seg_nb)
    );

    bin_to_seg_encoder #(.P_ACTIVE_LOW(1'b0), .P_BLANK_LZ(1'b1)) dut_ah (
        .i_clk(clk), .i_rst(rst), .i_value(value), .i_dp(dp), .i_valid(valid),
        .o_busy(busy_ah), .o_done(done_ah), .o_seg_data(seg_ah)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that raises o_done.
    task automatic convert(input string tag, input logic [13:0] v, input logic [3:0] d,
                           input logic [31:0] exp, input int glitch);
        int lat = 0;
        int busy_cnt = 0;
        bit found = 1'b0;
        valid = 1'b1;
        value = v;
        dp    = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
        value = 14'($urandom);
        dp    = 4'($urandom);
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (lat == glitch) begin
                valid = 1'b1;
                value = 14'd5555;
            end else begin
                valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        valid = 1'b0;
        $display("conv %s value=%0d dp=%b seg=%h latency=%0d busy_cycles=%0d",
                 tag, v, d, seg, lat, busy_cnt);
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd15);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd15);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_seg"}, seg, exp);
    endtask

    initial begin
        int seen;
        rst   = 1'b1;
        valid = 1'b0;
        value = '0;
        dp    = '0;
        idle(2);
        $display("reset seg=%h busy=%b done=%b", seg, busy, done);
        check("rst_seg", seg, 32'hFFFF_FFFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_seg_ah", seg_ah, 32'h0000_0000);
        rst = 1'b0;
        idle(2);

        convert("v1234", 14'd1234, 4'b0000, 32'hF9A4_B099, -1);
        check("v1234_nb", seg_nb, 32'hF9A4_B099);
        idle(1);
        check("done_one_cycle", 32'(done), 32'd0);
        idle(2);
        check("seg_hold", seg, 32'hF9A4_B099);

        convert("v42", 14'd42, 4'b0000, 32'hFFFF_99A4, -1);
        check("v42_nb", seg_nb, 32'hC0C0_99A4);
        check("v42_ah", seg_ah, 32'h0000_665B);
        idle(3);

        convert("v0", 14'd0, 4'b0000, 32'hFFFF_FFC0, -1);
        check("v0_nb", seg_nb, 32'hC0C0_C0C0);
        idle(3);

        convert("v1000", 14'd1000, 4'b0000, 32'hF9C0_C0C0, -1);
        idle(3);

        convert("v9999_dp", 14'd9999, 4'b0100, 32'h9010_9090, -1);
        check("v9999_dp_ah", seg_ah, 32'h6FEF_6F6F);
        idle(3);

        convert("ovf10000", 14'd10000, 4'b0000, 32'hBFBF_BFBF, -1);
        check("ovf10000_nb", seg_nb, 32'hBFBF_BFBF);
        idle(3);

        convert("ovf16383_dp", 14'd16383, 4'b0001, 32'hBFBF_BF3F, -1);
        check("ovf16383_dp_ah", seg_ah, 32'h4040_40C0);
        idle(3);

        convert("busy_ignore", 14'd1234, 4'b0000, 32'hF9A4_B099, 5);
        idle(1);
        check("busy_ignore_idle", 32'(busy), 32'd0);
        idle(2);

        convert("b2b_first", 14'd42, 4'b0000, 32'hFFFF_99A4, -1);
        convert("b2b_second", 14'd1000, 4'b0000, 32'hF9C0_C0C0, -1);
        idle(3);

        // Abort a conversion with reset partway through.
        valid = 1'b1;
        value = 14'd1234;
        dp    = 4'b0000;
        idle(1);
        valid = 1'b0;
        idle(7);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (20) begin
            if (done) seen++;
            @(posedge clk);
            #1;
        end
        $display("reset_mid seg=%h done_pulses=%0d", seg, seen);
        check("rst_mid_no_done", 32'(seen), 32'd0);
        check("rst_mid_seg", seg, 32'hFFFF_FFFF);
        check("rst_mid_seg_ah", seg_ah, 32'h0000_0000);

        convert("after_rst", 14'd42, 4'b0000, 32'hFFFF_99A4, -1);
        idle(2);

        // Reset and request together: the request must be dropped.
        rst   = 1'b1;
        valid = 1'b1;
        value = 14'd1234;
        idle(1);
        rst   = 1'b0;
        valid = 1'b0;
        check("rst_valid_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (20) begin
            if (done) seen++;
            @(posedge clk);
            #1;
        end
        $display("reset_with_valid seg=%h done_pulses=%0d", seg, seen);
        check("rst_valid_no_done", 32'(seen), 32'd0);
        check("rst_valid_seg", seg, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
